// File: rtl/regfile_bypass_if.sv
// Register-file access bundle: one write port and two combinational read ports.
// The master drives indices and write data; the slave (the register file) returns read data.
interface regfile_bypass_if #(
  parameter int WIDTH = 64
);
  logic             RegWrite;
  logic [4:0]       WriteRegister;
  logic [WIDTH-1:0] WriteData;
  logic [4:0]       ReadRegister1;
  logic [4:0]       ReadRegister2;
  logic [WIDTH-1:0] ReadData1;
  logic [WIDTH-1:0] ReadData2;

  modport master (
    output RegWrite,
    output WriteRegister,
    output WriteData,
    output ReadRegister1,
    output ReadRegister2,
    input  ReadData1,
    input  ReadData2
  );

  modport slave (
    input  RegWrite,
    input  WriteRegister,
    input  WriteData,
    input  ReadRegister1,
    input  ReadRegister2,
    output ReadData1,
    output ReadData2
  );
endinterface

// File: rtl/regfile_bypass.sv
// 32 x WIDTH register file: one write port and two zero-latency read ports with a same-cycle write bypass.
// Index ZERO_REG is hardwired to zero; reset is synchronous and active-high; there is no backpressure.
module regfile_bypass #(
  parameter int WIDTH    = 64,
  parameter int ZERO_REG = 31
) (
  input logic             clk,
  input logic             reset,
  regfile_bypass_if.slave rf
);
  localparam int         NREG     = 32;
  localparam logic [4:0] ZERO_IDX = 5'(ZERO_REG);

  logic [NREG-1:0]  wr_en;
  logic [WIDTH-1:0] regs_q [NREG];
  logic [WIDTH-1:0] regs_d [NREG];
  logic             byp1;
  logic             byp2;
  logic [WIDTH-1:0] rd1;
  logic [WIDTH-1:0] rd2;

  // One-hot write decode; the zero register never gets an enable and its next state is tied to 0.
  for (genvar i = 0; i < NREG; i++) begin : g_reg
    if (i == ZERO_REG) begin : g_zero
      assign wr_en[i]  = 1'b0;
      assign regs_d[i] = '0;
    end else begin : g_data
      assign wr_en[i]  = rf.RegWrite && (rf.WriteRegister == 5'(i));
      assign regs_d[i] = wr_en[i] ? rf.WriteData : regs_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREG; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // Bypass forwards the in-flight write, except under reset where the write is about to be dropped.
  assign byp1 = !reset && rf.RegWrite && (rf.WriteRegister == rf.ReadRegister1)
                && (rf.WriteRegister != ZERO_IDX);
  assign byp2 = !reset && rf.RegWrite && (rf.WriteRegister == rf.ReadRegister2)
                && (rf.WriteRegister != ZERO_IDX);

  always_comb begin
    rd1 = regs_q[rf.ReadRegister1];
    if (rf.ReadRegister1 == ZERO_IDX) begin
      rd1 = '0;
    end else if (byp1) begin
      rd1 = rf.WriteData;
    end
  end

  always_comb begin
    rd2 = regs_q[rf.ReadRegister2];
    if (rf.ReadRegister2 == ZERO_IDX) begin
      rd2 = '0;
    end else if (byp2) begin
      rd2 = rf.WriteData;
    end
  end

  assign rf.ReadData1 = rd1;
  assign rf.ReadData2 = rd2;
endmodule

// File: tb/tb_regfile_bypass.sv
// Directed bench for regfile_bypass: stimulus queues expected read data, a negedge monitor compares.
module tb_regfile_bypass;
  logic clk;
  logic reset;

  regfile_bypass_if #(.WIDTH(64)) rf ();

  regfile_bypass #(.WIDTH(64), .ZERO_REG(31)) dut (
    .clk  (clk),
    .reset(reset),
    .rf   (rf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [63:0] d1;
    logic [63:0] d2;
  } exp_t;

  exp_t exp_q[$];
  int   tests  = 0;
  int   errors = 0;

  function automatic logic [63:0] pat(input int i);
    return 64'h0101_0101_0101_0101 * 64'(i);
  endfunction

  // Monitor: the read ports are combinational, so each queued entry is checked mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      tests++;
      if (rf.ReadData1 !== e.d1) begin
        errors++;
        $display("FAIL %s port1: got %h expected %h", e.name, rf.ReadData1, e.d1);
      end
      tests++;
      if (rf.ReadData2 !== e.d2) begin
        errors++;
        $display("FAIL %s port2: got %h expected %h", e.name, rf.ReadData2, e.d2);
      end
    end
  end

  // Drive one cycle just after the rising edge; optionally queue the expected pre-edge reads.
  task automatic cyc(input logic rst, input logic we, input logic [4:0] wr,
                     input logic [63:0] wd, input logic [4:0] r1, input logic [4:0] r2,
                     input bit chk, input logic [63:0] e1, input logic [63:0] e2,
                     input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    reset            = rst;
    rf.RegWrite      = we;
    rf.WriteRegister = wr;
    rf.WriteData     = wd;
    rf.ReadRegister1 = r1;
    rf.ReadRegister2 = r2;
    if (chk) begin
      e.name = nm;
      e.d1   = e1;
      e.d2   = e2;
      exp_q.push_back(e);
    end
  endtask

  initial begin
    reset            = 1'b1;
    rf.RegWrite      = 1'b0;
    rf.WriteRegister = '0;
    rf.WriteData     = '0;
    rf.ReadRegister1 = '0;
    rf.ReadRegister2 = '0;

    // Reset: reads are zero while reset stays high, then everything reads zero.
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, "");
    cyc(1, 1, 3, 64'h99, 3, 3, 1, 0, 0, "in_reset_rd3");
    for (int i = 0; i < 32; i++)
      cyc(0, 0, 0, 0, 5'(i), 5'(31 - i), 1, 0, 0, $sformatf("reset_rd%0d", i));

    // Fill 0..30 with the pattern; each write is bypassed to both ports that cycle.
    for (int i = 0; i < 31; i++)
      cyc(0, 1, 5'(i), pat(i), 5'(i), 5'(i), 1, pat(i), pat(i), $sformatf("wr_byp%0d", i));
    for (int i = 0; i < 32; i++)
      cyc(0, 0, 0, 0, 5'(i), 5'((i + 1) % 32), 1, (i == 31) ? 64'h0 : pat(i),
          (i == 30) ? 64'h0 : pat((i + 1) % 32), $sformatf("stored_rd%0d", i));

    // Writes to the zero register are dropped and never bypassed.
    cyc(0, 1, 31, 64'hFFFF_FFFF_FFFF_FFFF, 31, 31, 1, 0, 0, "zero_wr_same");
    cyc(0, 0, 0, 0, 31, 30, 1, 0, pat(30), "zero_wr_after");

    // Overwrite with both ports on the same index.
    cyc(0, 1, 5, 64'hA, 5, 4, 1, 64'hA, pat(4), "r5_wrA");
    cyc(0, 1, 5, 64'hB, 5, 5, 1, 64'hB, 64'hB, "r5_wrB_byp");
    cyc(0, 0, 5, 64'hC, 5, 5, 1, 64'hB, 64'hB, "r5_after");

    // RegWrite=0: no bypass, no change.
    cyc(0, 0, 7, 64'h1234, 7, 7, 1, pat(7), pat(7), "r7_nowe");
    cyc(0, 0, 0, 0, 7, 6, 1, pat(7), pat(6), "r7_hold");

    // Bypass on one port only; the other port reads stored data.
    cyc(0, 1, 10, 64'hDEAD_BEEF, 10, 11, 1, 64'hDEAD_BEEF, pat(11), "byp_port1_only");
    cyc(0, 1, 12, 64'h5A5A, 13, 12, 1, pat(13), 64'h5A5A, "byp_port2_only");
    cyc(0, 0, 0, 0, 10, 12, 1, 64'hDEAD_BEEF, 64'h5A5A, "byp_stored");

    // Reset with a simultaneous write: bypass suppressed, write lost, all state cleared.
    cyc(0, 1, 3, 64'h55, 3, 2, 1, 64'h55, pat(2), "r3_wr55");
    cyc(1, 1, 3, 64'h77, 3, 3, 1, 64'h55, 64'h55, "rst_wr_pre");
    cyc(1, 1, 3, 64'h77, 3, 5, 1, 0, 0, "rst_wr_post");
    cyc(0, 0, 0, 0, 3, 5, 1, 0, 0, "post_rst_r3_r5");
    cyc(0, 0, 0, 0, 10, 30, 1, 0, 0, "post_rst_r10_r30");

    @(posedge clk);
    #1;
    rf.RegWrite = 1'b0;
    repeat (4) @(posedge clk);
    tests++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end
endmodule
